request_tracker: RTL and testbench

Parametrised elevator request register for N floors: accepts button events over a valid/ready handshake, holds cabin, hall-up and hall-down request vectors plus door-button flags, and applies the controller's floor-clear commands. It also provides the pending-above/below/here summary and the next target floor in the current travel direction. It sits between the keyboard decoder (which now emits typed floor-index events instead of raw key codes) and the elevator control FSM.

---
 rtl/request_tracker.sv | 188 ++++++++++++++++++
 tb/tb_request_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/request_tracker.sv
// Elevator request register: latches cabin/hall/door button events, applies
// controller floor clears, and derives pending summaries and the next target floor.
module request_tracker #(
    parameter int unsigned N_FLOORS    = 6,
    parameter int unsigned FLOOR_W     = 3,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [1:0]          req_type,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic                req_ready,
    output logic                req_err,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                dir_up,
    input  logic                clr_stop,
    input  logic                clr_dir,
    input  logic                clr_all,
    input  logic                clr_door,
    output logic [N_FLOORS-1:0] cabin_req,
    output logic [N_FLOORS-1:0] up_req,
    output logic [N_FLOORS-1:0] down_req,
    output logic                close_button,
    output logic                open_button,
    output logic                pending_here,
    output logic                pending_above,
    output logic                pending_below,
    output logic                target_valid,
    output logic [FLOOR_W-1:0]  target_floor
);

    localparam int unsigned CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] T_CABIN = 2'd0;
    localparam logic [1:0] T_UP    = 2'd1;
    localparam logic [1:0] T_DOWN  = 2'd2;
    localparam logic [1:0] T_DOOR  = 2'd3;

    logic [N_FLOORS-1:0] req_hot;
    logic [N_FLOORS-1:0] cur_hot;
    logic [N_FLOORS-1:0] any_req;
    logic                req_in_range;
    logic                req_legal;
    logic                accept;

    logic [N_FLOORS-1:0] cabin_nx;
    logic [N_FLOORS-1:0] up_nx;
    logic [N_FLOORS-1:0] down_nx;
    logic                open_nx;
    logic                close_nx;
    logic                err_nx;
    logic [CNT_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]    cnt_nx;

    // One-hot floor decodes; an out-of-range index decodes to all zeros,
    // which makes clears at an invalid cur_floor harmless by construction.
    always_comb begin : decode
        req_hot = '0;
        cur_hot = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            req_hot[i] = (32'(req_floor) == i);
            cur_hot[i] = (32'(cur_floor) == i);
        end
    end

    assign req_in_range = (32'(req_floor) < N_FLOORS);
    assign accept       = req_valid && req_ready;
    assign req_ready    = !reset && !(clr_stop || clr_dir || clr_all);
    assign any_req      = cabin_req | up_req | down_req;

    always_comb begin : legality
        req_legal = 1'b0;
        case (req_type)
            T_CABIN: req_legal = req_in_range;
            T_UP:    req_legal = req_in_range && (32'(req_floor) != N_FLOORS - 1);
            T_DOWN:  req_legal = req_in_range && (32'(req_floor) != 0);
            T_DOOR:  req_legal = (32'(req_floor) <= 1);
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin : next_state
        cabin_nx = cabin_req;
        up_nx    = up_req;
        down_nx  = down_req;
        open_nx  = open_button;
        close_nx = close_button;
        cnt_nx   = hold_cnt;
        err_nx   = accept && !req_legal;

        // Floor vectors: clears and accepted requests are mutually exclusive.
        if (clr_all) begin
            cabin_nx = '0;
            up_nx    = '0;
            down_nx  = '0;
        end else if (clr_stop) begin
            cabin_nx = cabin_req & ~cur_hot;
            up_nx    = up_req & ~cur_hot;
            down_nx  = down_req & ~cur_hot;
        end else if (clr_dir) begin
            cabin_nx = cabin_req & ~cur_hot;
            if (dir_up) begin
                up_nx = up_req & ~cur_hot;
            end else begin
                down_nx = down_req & ~cur_hot;
            end
        end else if (accept && req_legal) begin
            case (req_type)
                T_CABIN: cabin_nx = cabin_req | req_hot;
                T_UP:    up_nx    = up_req | req_hot;
                T_DOWN:  down_nx  = down_req | req_hot;
                default: ;
            endcase
        end

        // Door buttons: timeout, then explicit clear, then a new press overrides both.
        if ((HOLD_CYCLES != 0) && (open_button || close_button) && (hold_cnt != '0)) begin
            cnt_nx = hold_cnt - CNT_W'(1);
            if (hold_cnt == CNT_W'(1)) begin
                open_nx  = 1'b0;
                close_nx = 1'b0;
            end
        end
        if (clr_door) begin
            open_nx  = 1'b0;
            close_nx = 1'b0;
            cnt_nx   = '0;
        end
        if (accept && req_legal && (req_type == T_DOOR)) begin
            open_nx  = req_floor[0];
            close_nx = !req_floor[0];
            cnt_nx   = CNT_W'(HOLD_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cabin_req    <= '0;
            up_req       <= '0;
            down_req     <= '0;
            open_button  <= 1'b0;
            close_button <= 1'b0;
            hold_cnt     <= '0;
            req_err      <= 1'b0;
        end else begin
            cabin_req    <= cabin_nx;
            up_req       <= up_nx;
            down_req     <= down_nx;
            open_button  <= open_nx;
            close_button <= close_nx;
            hold_cnt     <= cnt_nx;
            req_err      <= err_nx;
        end
    end

    always_comb begin : summary
        pending_here  = |(any_req & cur_hot);
        pending_above = 1'b0;
        pending_below = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (any_req[i] && (i > 32'(cur_floor))) pending_above = 1'b1;
            if (any_req[i] && (i < 32'(cur_floor))) pending_below = 1'b1;
        end
    end

    // Nearest request in the travel direction, including the current floor.
    always_comb begin : target
        target_valid = 1'b0;
        target_floor = '0;
        if (dir_up) begin
            for (int i = int'(N_FLOORS) - 1; i >= 0; i--) begin
                if (any_req[i] && ($unsigned(i) >= 32'(cur_floor))) begin
                    target_valid = 1'b1;
                    target_floor = FLOOR_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(N_FLOORS); i++) begin
                if (any_req[i] && ($unsigned(i) <= 32'(cur_floor))) begin
                    target_valid = 1'b1;
                    target_floor = FLOOR_W'(i);
                end
            end
        end
    end

endmodule

// File: tb/tb_request_tracker.sv
// Directed bench for request_tracker: default 6-floor build plus 2- and 16-floor builds.
module tb_request_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, req_valid, dir_up;
    logic [1:0] req_type;
    logic [2:0] req_floor, cur_floor;
    logic       clr_stop, clr_dir, clr_all, clr_door;
    logic       req_ready, req_err, close_button, open_button;
    logic       pending_here, pending_above, pending_below, target_valid;
    logic [5:0] cabin_req, up_req, down_req;
    logic [2:0] target_floor;

    logic       v2, rdy2, err2, cb2, ob2, ph2, pa2, pb2, tv2;
    logic [0:0] f2, c2, tf2;
    logic [1:0] cab2, up2, dn2;

    logic        v16, rdy16, err16, cb16, ob16, ph16, pa16, pb16, tv16;
    logic [3:0]  f16, c16, tf16;
    logic [15:0] cab16, up16, dn16;

    int n_chk = 0;
    int n_pass = 0;

    request_tracker #(.N_FLOORS(6), .FLOOR_W(3), .HOLD_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_floor(req_floor), .req_ready(req_ready), .req_err(req_err),
        .cur_floor(cur_floor), .dir_up(dir_up), .clr_stop(clr_stop), .clr_dir(clr_dir),
        .clr_all(clr_all), .clr_door(clr_door), .cabin_req(cabin_req), .up_req(up_req),
        .down_req(down_req), .close_button(close_button), .open_button(open_button),
        .pending_here(pending_here), .pending_above(pending_above),
        .pending_below(pending_below), .target_valid(target_valid),
        .target_floor(target_floor));

    request_tracker #(.N_FLOORS(2), .FLOOR_W(1), .HOLD_CYCLES(8)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_type(req_type),
        .req_floor(f2), .req_ready(rdy2), .req_err(err2),
        .cur_floor(c2), .dir_up(dir_up), .clr_stop(clr_stop), .clr_dir(clr_dir),
        .clr_all(clr_all), .clr_door(clr_door), .cabin_req(cab2), .up_req(up2),
        .down_req(dn2), .close_button(cb2), .open_button(ob2),
        .pending_here(ph2), .pending_above(pa2), .pending_below(pb2),
        .target_valid(tv2), .target_floor(tf2));

    request_tracker #(.N_FLOORS(16), .FLOOR_W(4), .HOLD_CYCLES(8)) dut16 (
        .clk(clk), .reset(reset), .req_valid(v16), .req_type(req_type),
        .req_floor(f16), .req_ready(rdy16), .req_err(err16),
        .cur_floor(c16), .dir_up(dir_up), .clr_stop(clr_stop), .clr_dir(clr_dir),
        .clr_all(clr_all), .clr_door(clr_door), .cabin_req(cab16), .up_req(up16),
        .down_req(dn16), .close_button(cb16), .open_button(ob16),
        .pending_here(ph16), .pending_above(pa16), .pending_below(pb16),
        .target_valid(tv16), .target_floor(tf16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [2:0] f);
        req_valid = 1'b1;
        req_type  = t;
        req_floor = f;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_type = 2'd0; req_floor = 3'd0;
        cur_floor = 3'd0; dir_up = 1'b1;
        clr_stop = 1'b0; clr_dir = 1'b0; clr_all = 1'b0; clr_door = 1'b0;
        v2 = 1'b0; f2 = 1'b0; c2 = 1'b0; v16 = 1'b0; f16 = 4'd0; c16 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%b want=0", req_ready); else n_pass++;
        n_chk++; if ({cabin_req, up_req, down_req} !== 18'd0) $display("FAIL rst_vectors got=%h want=0", {cabin_req, up_req, down_req}); else n_pass++;
        n_chk++; if ({open_button, close_button, req_err} !== 3'b000) $display("FAIL rst_flags got=%b want=000", {open_button, close_button, req_err}); else n_pass++;
        n_chk++; if ({target_valid, pending_here, pending_above, pending_below} !== 4'd0) $display("FAIL rst_summary got=%b want=0000", {target_valid, pending_here, pending_above, pending_below}); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got=%b want=1", req_ready); else n_pass++;
    endtask

    task automatic test_requests();
        req_valid = 1'b1; req_type = 2'd0; req_floor = 3'd2;
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL req_ready got=%b want=1", req_ready); else n_pass++;
        tick();
        n_chk++; if (cabin_req !== 6'b000100) $display("FAIL cab2 got=%b want=000100", cabin_req); else n_pass++;
        send(2'd1, 3'd0);
        n_chk++; if (up_req !== 6'b000001) $display("FAIL up0 got=%b want=000001", up_req); else n_pass++;
        send(2'd2, 3'd5);
        n_chk++; if (down_req !== 6'b100000) $display("FAIL down5 got=%b want=100000", down_req); else n_pass++;
        n_chk++; if (req_err !== 1'b0) $display("FAIL legal_no_err got=%b want=0", req_err); else n_pass++;
        cur_floor = 3'd3; dir_up = 1'b1;
        #1;
        n_chk++; if ({target_valid, target_floor} !== {1'b1, 3'd5}) $display("FAIL tgt_up got=%b/%0d want=1/5", target_valid, target_floor); else n_pass++;
        n_chk++; if ({pending_above, pending_below, pending_here} !== 3'b110) $display("FAIL pend_3 got=%b want=110", {pending_above, pending_below, pending_here}); else n_pass++;
        dir_up = 1'b0;
        #1;
        n_chk++; if ({target_valid, target_floor} !== {1'b1, 3'd2}) $display("FAIL tgt_down got=%b/%0d want=1/2", target_valid, target_floor); else n_pass++;
    endtask

    task automatic test_illegal();
        send(2'd1, 3'd5);
        n_chk++; if (req_err !== 1'b1) $display("FAIL err_up_top got=%b want=1", req_err); else n_pass++;
        send(2'd2, 3'd0);
        n_chk++; if (req_err !== 1'b1) $display("FAIL err_down_bot got=%b want=1", req_err); else n_pass++;
        send(2'd0, 3'd7);
        n_chk++; if (req_err !== 1'b1) $display("FAIL err_cab_range got=%b want=1", req_err); else n_pass++;
        tick();
        n_chk++; if (req_err !== 1'b0) $display("FAIL err_pulse_end got=%b want=0", req_err); else n_pass++;
        n_chk++; if ({cabin_req, up_req, down_req} !== {6'b000100, 6'b000001, 6'b100000}) $display("FAIL illegal_unchanged got=%b_%b_%b", cabin_req, up_req, down_req); else n_pass++;
        send(2'd0, 3'd2);
        n_chk++; if ({req_err, cabin_req} !== {1'b0, 6'b000100}) $display("FAIL dup_set got=%b/%b want=0/000100", req_err, cabin_req); else n_pass++;
    endtask

    task automatic test_clear();
        cur_floor = 3'd2;
        clr_all = 1'b1; tick(); clr_all = 1'b0;
        send(2'd0, 3'd2); send(2'd1, 3'd2); send(2'd2, 3'd2);
        n_chk++; if ({cabin_req[2], up_req[2], down_req[2], pending_here} !== 4'b1111) $display("FAIL set_f2 got=%b want=1111", {cabin_req[2], up_req[2], down_req[2], pending_here}); else n_pass++;
        dir_up = 1'b1; clr_dir = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL ready_clr_dir got=%b want=0", req_ready); else n_pass++;
        tick(); clr_dir = 1'b0;
        n_chk++; if ({cabin_req, up_req, down_req} !== {6'd0, 6'd0, 6'b000100}) $display("FAIL after_clr_dir got=%b_%b_%b", cabin_req, up_req, down_req); else n_pass++;
        clr_stop = 1'b1;
        #1;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL ready_clr_stop got=%b want=0", req_ready); else n_pass++;
        tick(); clr_stop = 1'b0;
        n_chk++; if ({cabin_req, up_req, down_req, pending_here} !== 19'd0) $display("FAIL after_clr_stop got=%b_%b_%b", cabin_req, up_req, down_req); else n_pass++;
        send(2'd0, 3'd1); send(2'd2, 3'd3);
        dir_up = 1'b0; clr_dir = 1'b1; cur_floor = 3'd3; tick(); clr_dir = 1'b0;
        n_chk++; if ({cabin_req, down_req} !== {6'b000010, 6'd0}) $display("FAIL clr_dir_down got=%b_%b", cabin_req, down_req); else n_pass++;
        cur_floor = 3'd7; clr_stop = 1'b1; tick(); clr_stop = 1'b0;
        n_chk++; if (cabin_req !== 6'b000010) $display("FAIL clr_oob got=%b want=000010", cabin_req); else n_pass++;
        clr_all = 1'b1; tick(); clr_all = 1'b0;
        cur_floor = 3'd0;
    endtask

    task automatic test_door();
        send(2'd3, 3'd1);
        n_chk++; if ({open_button, close_button} !== 2'b10) $display("FAIL open_set got=%b want=10", {open_button, close_button}); else n_pass++;
        for (int j = 1; j < 8; j++) begin
            tick();
            n_chk++; if (open_button !== 1'b1) $display("FAIL open_hold_%0d got=%b want=1", j, open_button); else n_pass++;
        end
        tick();
        n_chk++; if (open_button !== 1'b0) $display("FAIL open_timeout got=%b want=0", open_button); else n_pass++;
        send(2'd3, 3'd1);
        tick(); tick();
        send(2'd3, 3'd0);
        n_chk++; if ({open_button, close_button} !== 2'b01) $display("FAIL close_over got=%b want=01", {open_button, close_button}); else n_pass++;
        repeat (7) tick();
        n_chk++; if (close_button !== 1'b1) $display("FAIL close_hold got=%b want=1", close_button); else n_pass++;
        tick();
        n_chk++; if (close_button !== 1'b0) $display("FAIL close_timeout got=%b want=0", close_button); else n_pass++;
        send(2'd3, 3'd1);
        tick();
        clr_door = 1'b1; tick(); clr_door = 1'b0;
        n_chk++; if ({open_button, close_button} !== 2'b00) $display("FAIL clr_door got=%b want=00", {open_button, close_button}); else n_pass++;
        req_valid = 1'b1; req_type = 2'd3; req_floor = 3'd0; clr_door = 1'b1;
        tick();
        req_valid = 1'b0; clr_door = 1'b0;
        n_chk++; if ({open_button, close_button} !== 2'b01) $display("FAIL door_wins got=%b want=01", {open_button, close_button}); else n_pass++;
        clr_door = 1'b1; tick(); clr_door = 1'b0;
        send(2'd3, 3'd2);
        n_chk++; if ({req_err, open_button, close_button} !== 3'b100) $display("FAIL door_illegal got=%b want=100", {req_err, open_button, close_button}); else n_pass++;
    endtask

    task automatic test_clr_all_reset();
        for (int i = 0; i < 6; i++) begin
            send(2'd0, 3'(i));
            if (i < 5) send(2'd1, 3'(i));
            if (i > 0) send(2'd2, 3'(i));
        end
        n_chk++; if ({cabin_req, up_req, down_req} !== {6'h3f, 6'h1f, 6'h3e}) $display("FAIL fill_all got=%b_%b_%b", cabin_req, up_req, down_req); else n_pass++;
        cur_floor = 3'd2; clr_all = 1'b1; clr_stop = 1'b1;
        tick();
        clr_all = 1'b0; clr_stop = 1'b0;
        n_chk++; if ({cabin_req, up_req, down_req} !== 18'd0) $display("FAIL clr_all got=%b_%b_%b", cabin_req, up_req, down_req); else n_pass++;
        send(2'd0, 3'd4);
        send(2'd3, 3'd1);
        #3;
        reset = 1'b1;
        #1;
        n_chk++; if ({cabin_req, open_button, req_ready} !== 8'd0) $display("FAIL async_rst got=%b/%b/%b want=0", cabin_req, open_button, req_ready); else n_pass++;
        tick();
        reset = 1'b0;
        cur_floor = 3'd0;
    endtask

    task automatic test_sweep();
        req_type = 2'd0; f2 = 1'b1; v2 = 1'b1; tick(); v2 = 1'b0;
        n_chk++; if (cab2 !== 2'b10) $display("FAIL n2_cab got=%b want=10", cab2); else n_pass++;
        c2 = 1'b0; dir_up = 1'b0; #1;
        n_chk++; if ({tv2, tf2} !== 2'b00) $display("FAIL n2_none got=%b want=00", {tv2, tf2}); else n_pass++;
        dir_up = 1'b1; #1;
        n_chk++; if ({tv2, tf2, pa2} !== 3'b111) $display("FAIL n2_up_top got=%b want=111", {tv2, tf2, pa2}); else n_pass++;
        req_type = 2'd1; f2 = 1'b0; v2 = 1'b1; tick();
        req_type = 2'd2; f2 = 1'b1; tick();
        req_type = 2'd1; f2 = 1'b1; tick(); v2 = 1'b0;
        n_chk++; if ({up2, dn2, err2} !== 5'b01101) $display("FAIL n2_vec got=%b want=01101", {up2, dn2, err2}); else n_pass++;
        c2 = 1'b0; dir_up = 1'b0; #1;
        n_chk++; if ({tv2, tf2} !== 2'b10) $display("FAIL n2_bot_dn got=%b want=10", {tv2, tf2}); else n_pass++;
        c2 = 1'b1; dir_up = 1'b1; #1;
        n_chk++; if ({tv2, tf2, pb2} !== 3'b111) $display("FAIL n2_top_up got=%b want=111", {tv2, tf2, pb2}); else n_pass++;

        req_type = 2'd0; f16 = 4'd15; v16 = 1'b1; tick();
        req_type = 2'd1; f16 = 4'd0; tick();
        req_type = 2'd2; f16 = 4'd15; tick();
        req_type = 2'd1; f16 = 4'd15; tick(); v16 = 1'b0;
        n_chk++; if ({cab16, up16, dn16, err16} !== {16'h8000, 16'h0001, 16'h8000, 1'b1}) $display("FAIL n16_vec got=%h_%h_%h_%b", cab16, up16, dn16, err16); else n_pass++;
        c16 = 4'd0; dir_up = 1'b1; #1;
        n_chk++; if ({tv16, tf16} !== {1'b1, 4'd0}) $display("FAIL n16_bot_up got=%b/%0d want=1/0", tv16, tf16); else n_pass++;
        dir_up = 1'b0; #1;
        n_chk++; if ({tv16, tf16} !== {1'b1, 4'd0}) $display("FAIL n16_bot_dn got=%b/%0d want=1/0", tv16, tf16); else n_pass++;
        c16 = 4'd15; #1;
        n_chk++; if ({tv16, tf16} !== {1'b1, 4'd15}) $display("FAIL n16_top_dn got=%b/%0d want=1/15", tv16, tf16); else n_pass++;
        dir_up = 1'b1; #1;
        n_chk++; if ({tv16, tf16} !== {1'b1, 4'd15}) $display("FAIL n16_top_up got=%b/%0d want=1/15", tv16, tf16); else n_pass++;
        c16 = 4'd7; #1;
        n_chk++; if ({tf16, pa16, pb16, ph16} !== {4'd15, 3'b110}) $display("FAIL n16_mid got=%0d/%b want=15/110", tf16, {pa16, pb16, ph16}); else n_pass++;
        dir_up = 1'b0; #1;
        n_chk++; if ({tv16, tf16} !== {1'b1, 4'd0}) $display("FAIL n16_mid_dn got=%b/%0d want=1/0", tv16, tf16); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_requests();
        test_illegal();
        test_clear();
        test_door();
        test_clr_all_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
